command_decoder: RTL and testbench
==================================

Name: command_decoder

Overview:
- Assembles the SUMP-style byte stream from the UART receiver into complete commands for the controller.
- Short commands (opcode bit 7 = 0) are one byte. Long commands (opcode bit 7 = 1) are one opcode byte plus four argument bytes, least-significant byte first.
- Presents opcode and command, then pulses cmd_recv_rx for one cycle.
- Sits between the UART receiver and the controller; an inter-byte timeout discards partial long commands.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: idle clock cycles allowed between bytes of a long command before it is discarded (10 ms at 100 MHz). Must be >= 2.
- TMR_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived; do not override).

Ports:
- clock, input, 1: system clock.
- ext_reset, input, 1: asynchronous, active-high reset.
- rx_data, input, 8: received byte, valid only when rx_valid = 1.
- rx_valid, input, 1: single-cycle strobe, one per received byte.
- opcode, output, 8: opcode of the last completed command.
- command, output, 32: argument of the last completed command; 0 for short commands.
- cmd_recv_rx, output, 1: single-cycle pulse when opcode/command hold a new command.
- long_cmd, output, 1: bit 7 of opcode, registered alongside opcode.
- timeout_err, output, 1: single-cycle pulse when a partial long command is discarded.
- busy, output, 1: high while collecting argument bytes (state ARGS).

Behaviour:
- Reset (async, ext_reset = 1):
  - State = IDLE; all outputs 0; byte index 0; timer 0; argument shift register 0.
  - Reset mid-command discards the partial command; no pulse is emitted.
- All outputs are registered.
- State IDLE:
  - rx_valid with rx_data[7] = 0 (short command): at that edge, opcode <= rx_data, command <= 0, long_cmd <= 0, cmd_recv_rx <= 1. State stays IDLE.
  - rx_valid with rx_data[7] = 1 (long command): latch the pending opcode internally, index <= 0, timer <= 0, go to ARGS. opcode/command outputs are unchanged.
- State ARGS:
  - On each rx_valid, store the byte into arg[8*index +: 8], increment index, clear the timer.
  - On the 4th byte (index = 3): at that edge, opcode <= pending, command <= assembled 32 bits (including the current byte), long_cmd <= 1, cmd_recv_rx <= 1, go to IDLE.
  - Without rx_valid, the timer increments. When timer = TIMEOUT_CYCLES-1 and rx_valid = 0: timeout_err <= 1, go to IDLE, discard. opcode/command are unchanged.
  - rx_valid on the same cycle the timer expires: the byte wins, the timer clears, no timeout.
- Latency: cmd_recv_rx asserts exactly one cycle after the rx_valid of the final byte. opcode/command are stable in that same cycle and hold until the next completed command.
- Back-to-back commands: because the FSM returns to IDLE on the completing edge, a byte arriving on the cycle cmd_recv_rx is high is accepted. No bytes are lost.
- cmd_recv_rx and timeout_err are never high together, and each is high for one cycle only.
- Opcode-agnostic: no decoding of meanings here. The SUMP reset sequence (five 0x00 bytes) produces five short-command pulses.
- busy = (state == ARGS).

Decomposition:
- Shared package analyzer_pkg:
  - Opcode constants: OP_RESET = 8'h00, OP_RUN = 8'h01, OP_ID = 8'h02, OP_META = 8'h04, OP_DIVIDER = 8'h80, OP_TRIG_MASK = 8'hC0, OP_TRIG_VAL = 8'hC1.
  - LONG_CMD_BIT = 7.
  - Typedef decoder_state {IDLE, ARGS}.
  - The controller imports the same constants.
- One sub-module, idle_timer:
  - Inputs: clear, enable.
  - Output: single-cycle expired flag.
  - Parameterised by TIMEOUT_CYCLES.
- All remaining logic stays in the top module.

Test Plan:
- Short command: byte 0x02 -> next cycle cmd_recv_rx = 1 for one cycle, opcode = 0x02, command = 0x00000000, long_cmd = 0.
- Long command: bytes 0x80, 0x0A, 0x0B, 0x0C, 0x00 with gaps of 3 cycles -> one pulse one cycle after the last byte, opcode = 0x80, command = 0x000C0B0A, long_cmd = 1, busy low afterwards.
- Timeout (TIMEOUT_CYCLES = 16): send 0xC0, 0x11, then silence -> timeout_err pulses once, no cmd_recv_rx, opcode/command keep their prior values. A following 0x04 decodes normally.
- Boundary: final byte delivered on exactly the expiry cycle -> command completes, no timeout_err. Then deliver one cycle later than expiry in a fresh run -> timeout_err, the late byte is treated as a new opcode.
- Back-to-back: 0xC1, 0xFF, 0x00, 0xFF, 0x00, then 0x01 on the cycle cmd_recv_rx is high -> two pulses: (0xC1, 0x00FF00FF), then (0x01, 0).
- Async reset asserted after the second argument byte -> all outputs 0 immediately, no pulse. A subsequent 0x00 yields opcode 0x00 with one pulse.

Source files
------------

// File: rtl/analyzer_pkg.sv
// Shared analyzer definitions: SUMP opcodes and decoder state encoding,
// imported by the command decoder and the controller.
package analyzer_pkg;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_RUN       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_META      = 8'h04;
    localparam logic [7:0] OP_DIVIDER   = 8'h80;
    localparam logic [7:0] OP_TRIG_MASK = 8'hC0;
    localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;

    localparam int LONG_CMD_BIT = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ARGS = 1'b1
    } decoder_state;

endpackage

// File: rtl/command_decoder_idle_timer.sv
// Inter-byte idle counter; flags expiry on the last allowed idle cycle.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock,
    input  logic ext_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST_COUNT = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count_r;

    // Idle cycle counter, wraps to zero on expiry
    always_ff @(posedge clock or posedge ext_reset) begin
        if (ext_reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            if (count_r == LAST_COUNT) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + TMR_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/command_decoder.sv
// Assembles SUMP short (1-byte) and long (opcode + 4 LSB-first bytes) commands
// from the UART byte stream; partial long commands are dropped after idle timeout.
module command_decoder
    import analyzer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        ext_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  opcode,
    output logic [31:0] command,
    output logic        cmd_recv_rx,
    output logic        long_cmd,
    output logic        timeout_err,
    output logic        busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    decoder_state state_r, state_nx_s;
    logic [7:0]   pend_r, pend_nx_s;
    logic [1:0]   idx_r, idx_nx_s;
    logic [31:0]  arg_r, arg_nx_s;
    logic [7:0]   opcode_r, opcode_nx_s;
    logic [31:0]  command_r, command_nx_s;
    logic         long_r, long_nx_s;
    logic         cmd_r, cmd_nx_s;
    logic         to_r, to_nx_s;
    logic         busy_r;
    logic         tmr_clear_s, tmr_enable_s, tmr_expired_s;

    assign tmr_clear_s  = (state_r == IDLE) || rx_valid;
    assign tmr_enable_s = (state_r == ARGS) && !rx_valid;

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_idle_timer (
        .clock     (clock),
        .ext_reset (ext_reset),
        .clear     (tmr_clear_s),
        .enable    (tmr_enable_s),
        .expired   (tmr_expired_s)
    );

    // Next-state and output decode; a byte always wins over a same-cycle expiry
    always_comb begin
        state_nx_s   = state_r;
        pend_nx_s    = pend_r;
        idx_nx_s     = idx_r;
        arg_nx_s     = arg_r;
        opcode_nx_s  = opcode_r;
        command_nx_s = command_r;
        long_nx_s    = long_r;
        cmd_nx_s     = 1'b0;
        to_nx_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data[LONG_CMD_BIT]) begin
                        pend_nx_s  = rx_data;
                        idx_nx_s   = 2'd0;
                        state_nx_s = ARGS;
                    end else begin
                        opcode_nx_s  = rx_data;
                        command_nx_s = 32'h0000_0000;
                        long_nx_s    = 1'b0;
                        cmd_nx_s     = 1'b1;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ARGS: begin
                if (rx_valid) begin
                    arg_nx_s[{idx_r, 3'b000} +: 8] = rx_data;
                    if (idx_r == 2'd3) begin
                        opcode_nx_s  = pend_r;
                        command_nx_s = {rx_data, arg_r[23:0]};
                        long_nx_s    = 1'b1;
                        cmd_nx_s     = 1'b1;
                        idx_nx_s     = 2'd0;
                        state_nx_s   = IDLE;
                    end else begin
                        idx_nx_s = idx_r + 2'd1;
                    end
                end else if (tmr_expired_s) begin
                    to_nx_s    = 1'b1;
                    idx_nx_s   = 2'd0;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ARGS;
                end
            end
            default: begin
                state_nx_s = IDLE;
                idx_nx_s   = 2'd0;
            end
        endcase
    end

    // State and registered output update
    always_ff @(posedge clock or posedge ext_reset) begin
        if (ext_reset) begin
            state_r   <= IDLE;
            pend_r    <= 8'h00;
            idx_r     <= 2'd0;
            arg_r     <= 32'h0000_0000;
            opcode_r  <= 8'h00;
            command_r <= 32'h0000_0000;
            long_r    <= 1'b0;
            cmd_r     <= 1'b0;
            to_r      <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pend_r    <= pend_nx_s;
            idx_r     <= idx_nx_s;
            arg_r     <= arg_nx_s;
            opcode_r  <= opcode_nx_s;
            command_r <= command_nx_s;
            long_r    <= long_nx_s;
            cmd_r     <= cmd_nx_s;
            to_r      <= to_nx_s;
            busy_r    <= (state_nx_s == ARGS);
        end
    end

    assign opcode      = opcode_r;
    assign command     = command_r;
    assign long_cmd    = long_r;
    assign cmd_recv_rx = cmd_r;
    assign timeout_err = to_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_command_decoder.sv
// Directed bench for command_decoder: table of complete commands plus
// hand-written timeout, boundary, back-to-back and reset sequences.
module tb_command_decoder;

    logic        clock = 1'b0;
    logic        ext_reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        long_cmd;
    logic        timeout_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_cmd = 0;
    int n_to = 0;
    int n_both = 0;

    command_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clock       (clock),
        .ext_reset   (ext_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .opcode      (opcode),
        .command     (command),
        .cmd_recv_rx (cmd_recv_rx),
        .long_cmd    (long_cmd),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cmd_recv_rx) n_cmd++;
        if (timeout_err) n_to++;
        if (cmd_recv_rx && timeout_err) n_both++;
    end

    typedef struct {
        logic [7:0]  b [5];
        int          n;
        int          gap;
        logic [7:0]  op;
        logic [31:0] cmd;
        logic        lng;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_cmd(input string name, input logic [7:0] op, input logic [31:0] cmd, input logic lng);
        chk({name, "_pulse"}, {31'd0, cmd_recv_rx}, 32'd1);
        chk({name, "_opcode"}, {24'd0, opcode}, {24'd0, op});
        chk({name, "_command"}, command, cmd);
        chk({name, "_long"}, {31'd0, long_cmd}, {31'd0, lng});
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    int c0, t0;

    initial begin
        vecs[0] = '{b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, gap: 0, op: 8'h02, cmd: 32'h0000_0000, lng: 1'b0};
        vecs[1] = '{b: '{8'h80, 8'h0A, 8'h0B, 8'h0C, 8'h00}, n: 5, gap: 3, op: 8'h80, cmd: 32'h000C_0B0A, lng: 1'b1};
        vecs[2] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, gap: 0, op: 8'h00, cmd: 32'h0000_0000, lng: 1'b0};
        vecs[3] = '{b: '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, gap: 0, op: 8'h04, cmd: 32'h0000_0000, lng: 1'b0};
        vecs[4] = '{b: '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12}, n: 5, gap: 1, op: 8'hC0, cmd: 32'h1234_5678, lng: 1'b1};

        ext_reset = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        idle(2);
        chk("rst_opcode", {24'd0, opcode}, 32'd0);
        chk("rst_command", command, 32'd0);
        chk("rst_flags", {26'd0, cmd_recv_rx, long_cmd, timeout_err, busy, 2'b00}, 32'd0);
        ext_reset = 1'b0;
        idle(1);

        for (int i = 0; i < 5; i++) begin
            c0 = n_cmd;
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(vecs[i].b[j]);
                if (j < vecs[i].n - 1) begin
                    chk($sformatf("v%0d_busy_mid", i), {31'd0, busy}, {31'd0, vecs[i].lng});
                    idle(vecs[i].gap);
                end
            end
            chk_cmd($sformatf("v%0d", i), vecs[i].op, vecs[i].cmd, vecs[i].lng);
            idle(1);
            chk($sformatf("v%0d_pulse_end", i), {31'd0, cmd_recv_rx}, 32'd0);
            chk($sformatf("v%0d_pulse_cnt", i), n_cmd - c0, 32'd1);
        end

        // timeout: prior command C0/12345678 must survive
        c0 = n_cmd; t0 = n_to;
        send_byte(8'hC0);
        send_byte(8'h11);
        idle(20);
        chk("to_err_cnt", n_to - t0, 32'd1);
        chk("to_cmd_cnt", n_cmd - c0, 32'd0);
        chk("to_opcode", {24'd0, opcode}, 32'h0000_00C0);
        chk("to_command", command, 32'h1234_5678);
        chk("to_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h04);
        chk_cmd("after_to", 8'h04, 32'h0000_0000, 1'b0);

        // final byte exactly on expiry cycle
        t0 = n_to;
        send_byte(8'hC0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle(15);
        send_byte(8'h04);
        chk_cmd("edge_ok", 8'hC0, 32'h0403_0201, 1'b1);
        chk("edge_ok_to", n_to - t0, 32'd0);

        // one cycle later: timeout, late byte becomes a new opcode
        idle(1);
        t0 = n_to;
        send_byte(8'hC0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle(16);
        send_byte(8'h05);
        chk("edge_late_to", n_to - t0, 32'd1);
        chk_cmd("edge_late", 8'h05, 32'h0000_0000, 1'b0);

        // back-to-back: 0x01 arrives while cmd_recv_rx is high
        idle(1);
        c0 = n_cmd;
        send_byte(8'hC1); send_byte(8'hFF); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
        chk_cmd("b2b_1", 8'hC1, 32'h00FF_00FF, 1'b1);
        send_byte(8'h01);
        chk_cmd("b2b_2", 8'h01, 32'h0000_0000, 1'b0);
        idle(1);
        chk("b2b_cnt", n_cmd - c0, 32'd2);

        // async reset mid-command
        c0 = n_cmd;
        send_byte(8'hC0); send_byte(8'h11); send_byte(8'h22);
        #2;
        ext_reset = 1'b1;
        #1;
        chk("arst_opcode", {24'd0, opcode}, 32'd0);
        chk("arst_command", command, 32'd0);
        chk("arst_flags", {28'd0, cmd_recv_rx, long_cmd, timeout_err, busy}, 32'd0);
        idle(2);
        ext_reset = 1'b0;
        idle(1);
        chk("arst_no_pulse", n_cmd - c0, 32'd0);
        send_byte(8'h00);
        chk_cmd("arst_after", 8'h00, 32'h0000_0000, 1'b0);
        idle(1);
        chk("arst_after_cnt", n_cmd - c0, 32'd1);

        chk("never_both", n_both, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
